// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state type and CRC-32 byte-step helper.
package eth_pkg;

   localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int          PREAMBLE_LEN  = 7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_SFD  = 3'd2,
      ST_DATA = 3'd3,
      ST_PAD  = 3'd4,
      ST_FCS  = 3'd5,
      ST_IFG  = 3'd6
   } tx_state_e;

   // Advance a reflected CRC-32 register by one byte, data bit 0 first.
   function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if ((c[0] ^ data[i]) == 1'b1) begin
            c = {1'b0, c[31:1]} ^ CRC32_POLY_R;
         end else begin
            c = {1'b0, c[31:1]};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-CRC for one byte; shared with the receive-side checker.
import eth_pkg::*;

module crc32_d8 (
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   // one byte of reflected CRC-32 update
   always_comb begin
      crc_out = crc32_step8(crc_in, data);
   end

endmodule

// File: rtl/add_crc.sv
// Transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS and inter-frame gap
// onto a GMII byte stream. Underrun (stream gap in DATA) closes the frame with a
// deliberately corrupted FCS flagged on tx_err.
import eth_pkg::*;

module add_crc #(
   parameter int MIN_FRAME = 60,
   parameter int IFG_LEN   = 12
) (
   input  logic       tx_clk,
   input  logic       rst_n,
   input  logic [7:0] raw_data,
   input  logic       raw_valid,
   input  logic       raw_last,
   output logic       raw_ready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       tx_err,
   output logic       busy
);

   localparam logic [10:0] CNT_MAX     = 11'h7FF;
   localparam logic [11:0] MIN_FRAME_C = 12'(MIN_FRAME);
   localparam logic [2:0]  PRE_LAST    = 3'(PREAMBLE_LEN - 2);
   localparam logic [7:0]  IFG_LAST    = 8'(IFG_LEN - 1);

   tx_state_e   state_r, state_s;
   logic [2:0]  pre_cnt_r, pre_cnt_s;
   logic [1:0]  fcs_cnt_r, fcs_cnt_s;
   logic [7:0]  ifg_cnt_r, ifg_cnt_s;
   logic [10:0] byte_cnt_r, byte_cnt_s;
   logic [10:0] byte_inc_s;
   logic [31:0] crc_r, crc_s;
   logic [31:0] crc_next_s;
   logic [31:0] fcs_s;
   logic [7:0]  crc_din_s;
   logic [7:0]  fcs_byte_s;
   logic        uf_r, uf_s;

   logic [7:0]  tx_data_s;
   logic        tx_en_s;
   logic        tx_err_s;
   logic        raw_ready_s;
   logic        busy_s;

   crc32_d8 u_crc32_d8 (
      .crc_in  (crc_r),
      .data    (crc_din_s),
      .crc_out (crc_next_s)
   );

   // CRC input byte, saturating byte counter and current FCS byte
   always_comb begin
      crc_din_s  = (state_r == ST_DATA) ? raw_data : 8'h00;
      byte_inc_s = (byte_cnt_r == CNT_MAX) ? CNT_MAX : (byte_cnt_r + 11'd1);
      fcs_s      = uf_r ? crc_r : ~crc_r;
      case (fcs_cnt_r)
         2'd0:    fcs_byte_s = fcs_s[7:0];
         2'd1:    fcs_byte_s = fcs_s[15:8];
         2'd2:    fcs_byte_s = fcs_s[23:16];
         2'd3:    fcs_byte_s = fcs_s[31:24];
         default: fcs_byte_s = 8'h00;
      endcase
   end

   // framer FSM: next state, counters, CRC and next output values
   always_comb begin
      state_s     = state_r;
      pre_cnt_s   = pre_cnt_r;
      fcs_cnt_s   = fcs_cnt_r;
      ifg_cnt_s   = ifg_cnt_r;
      byte_cnt_s  = byte_cnt_r;
      crc_s       = crc_r;
      uf_s        = uf_r;
      tx_data_s   = 8'h00;
      tx_en_s     = 1'b0;
      tx_err_s    = 1'b0;
      raw_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (raw_valid) begin
               state_s    = ST_PRE;
               pre_cnt_s  = 3'd0;
               byte_cnt_s = 11'd0;
               crc_s      = CRC32_INIT;
               uf_s       = 1'b0;
               tx_en_s    = 1'b1;
               tx_data_s  = PREAMBLE_BYTE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PRE: begin
            tx_en_s   = 1'b1;
            tx_data_s = PREAMBLE_BYTE;
            if (pre_cnt_r == PRE_LAST) begin
               state_s = ST_SFD;
            end else begin
               pre_cnt_s = pre_cnt_r + 3'd1;
            end
         end
         ST_SFD: begin
            tx_en_s     = 1'b1;
            tx_data_s   = SFD_BYTE;
            raw_ready_s = 1'b1;
            state_s     = ST_DATA;
         end
         ST_DATA: begin
            tx_en_s = 1'b1;
            if (raw_valid) begin
               tx_data_s  = raw_data;
               crc_s      = crc_next_s;
               byte_cnt_s = byte_inc_s;
               if (raw_last) begin
                  fcs_cnt_s = 2'd0;
                  if ({1'b0, byte_inc_s} < MIN_FRAME_C) begin
                     state_s = ST_PAD;
                  end else begin
                     state_s = ST_FCS;
                  end
               end else begin
                  raw_ready_s = 1'b1;
               end
            end else begin
               // stream gap: the slot becomes the first (uninverted) FCS byte
               uf_s      = 1'b1;
               tx_err_s  = 1'b1;
               tx_data_s = crc_r[7:0];
               fcs_cnt_s = 2'd1;
               state_s   = ST_FCS;
            end
         end
         ST_PAD: begin
            tx_en_s    = 1'b1;
            tx_data_s  = 8'h00;
            crc_s      = crc_next_s;
            byte_cnt_s = byte_inc_s;
            if ({1'b0, byte_inc_s} >= MIN_FRAME_C) begin
               fcs_cnt_s = 2'd0;
               state_s   = ST_FCS;
            end else begin
               state_s = ST_PAD;
            end
         end
         ST_FCS: begin
            tx_en_s   = 1'b1;
            tx_err_s  = uf_r;
            tx_data_s = fcs_byte_s;
            if (fcs_cnt_r == 2'd3) begin
               ifg_cnt_s = 8'd0;
               state_s   = ST_IFG;
            end else begin
               fcs_cnt_s = fcs_cnt_r + 2'd1;
            end
         end
         ST_IFG: begin
            if (ifg_cnt_r == IFG_LAST) begin
               state_s = ST_IDLE;
            end else begin
               ifg_cnt_s = ifg_cnt_r + 8'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // FSM state, counters and CRC register
   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         pre_cnt_r  <= 3'd0;
         fcs_cnt_r  <= 2'd0;
         ifg_cnt_r  <= 8'd0;
         byte_cnt_r <= 11'd0;
         crc_r      <= CRC32_INIT;
         uf_r       <= 1'b0;
      end else begin
         state_r    <= state_s;
         pre_cnt_r  <= pre_cnt_s;
         fcs_cnt_r  <= fcs_cnt_s;
         ifg_cnt_r  <= ifg_cnt_s;
         byte_cnt_r <= byte_cnt_s;
         crc_r      <= crc_s;
         uf_r       <= uf_s;
      end
   end

   // registered GMII outputs and upstream handshake
   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data   <= 8'h00;
         tx_en     <= 1'b0;
         tx_err    <= 1'b0;
         raw_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         tx_data   <= tx_data_s;
         tx_en     <= tx_en_s;
         tx_err    <= tx_err_s;
         raw_ready <= raw_ready_s;
         busy      <= busy_s;
      end
   end

endmodule
